// File: rtl/counter_game_master.sv
`timescale 1ns/1ps
// counter_game_master
// Initiator side of the multi-mode counter game. Loads the counter, runs
// one round per start request, keeps its own WINNER/LOSER tallies,
// optionally bounces the count direction on every event, and checks the
// counter's GAMEOVER/WHO verdict against those tallies.
//
// Ports:
//   clk, rst_l             clock, async active-low reset
//   start, mode, bounce    round request, initial ctrl, bounce enable
//   seed                   counter load value for the round
//   ctrl, INIT, loadValue  counter control outputs
//   WINNER, LOSER          counter event pulses
//   GAMEOVER, WHO          counter round end and verdict
//   busy, done             round in progress, one-cycle completion pulse
//   result                 WHO latched at GAMEOVER (00 on timeout)
//   win_cnt, lose_cnt      local saturating tallies
//   err                    round error flag, held until next start
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | INIT strobe to the counter
// RUN   | tallying events, waiting for GAMEOVER or timeout
// DONE  | done pulse, then back to IDLE
module counter_game_master #(
  parameter int COUNTER_SIZE = 4,
  parameter int EVT_LIMIT    = 15,
  parameter int TIMEOUT      = 1023,
  parameter int TO_W         = 10
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    bounce,
  input  logic [COUNTER_SIZE-1:0] seed,
  output logic [1:0]              ctrl,
  output logic                    INIT,
  output logic [COUNTER_SIZE-1:0] loadValue,
  input  logic                    WINNER,
  input  logic                    LOSER,
  input  logic                    GAMEOVER,
  input  logic [1:0]              WHO,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              result,
  output logic [3:0]              win_cnt,
  output logic [3:0]              lose_cnt,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state_q;
  logic [1:0]              ctrl_q, ctrl_d;
  logic                    init_q;
  logic [COUNTER_SIZE-1:0] load_q;
  logic                    busy_q;
  logic                    done_q;
  logic [1:0]              result_q;
  logic [3:0]              win_q, win_d;
  logic [3:0]              lose_q, lose_d;
  logic                    err_q;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    both_evt;
  logic                    verdict_ok;
  logic                    timeout_hit;

  // RUN-cycle next values. The verdict uses the post-event tallies because
  // the final WINNER/LOSER pulse arrives together with GAMEOVER.
  always_comb begin
    both_evt = WINNER & LOSER;
    win_d    = win_q;
    lose_d   = lose_q;
    ctrl_d   = ctrl_q;
    if (!both_evt) begin
      if (WINNER) begin
        win_d = (win_q == 4'hF) ? 4'hF : win_q + 4'd1;
        if (bounce) ctrl_d = {1'b1, ctrl_q[0]};
      end
      if (LOSER) begin
        lose_d = (lose_q == 4'hF) ? 4'hF : lose_q + 4'd1;
        if (bounce) ctrl_d = {1'b0, ctrl_q[0]};
      end
    end
    to_d        = to_q + TO_W'(1);
    timeout_hit = (to_d == TO_W'(TIMEOUT));
    verdict_ok  = ((WHO == 2'b01) && (lose_d == 4'(EVT_LIMIT))) ||
                  ((WHO == 2'b10) && (win_d  == 4'(EVT_LIMIT)));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      ctrl_q   <= 2'b00;
      init_q   <= 1'b0;
      load_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 2'b00;
      win_q    <= 4'd0;
      lose_q   <= 4'd0;
      err_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            load_q   <= seed;
            ctrl_q   <= mode;
            win_q    <= 4'd0;
            lose_q   <= 4'd0;
            err_q    <= 1'b0;
            result_q <= 2'b00;
            to_q     <= '0;
            busy_q   <= 1'b1;
            init_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          init_q  <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          win_q  <= win_d;
          lose_q <= lose_d;
          ctrl_q <= ctrl_d;
          to_q   <= to_d;
          if (both_evt) err_q <= 1'b1;
          // GAMEOVER takes priority over a coincident timeout.
          if (GAMEOVER) begin
            result_q <= WHO;
            if (!verdict_ok) err_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (timeout_hit) begin
            result_q <= 2'b00;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl      = ctrl_q;
  assign INIT      = init_q;
  assign loadValue = load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign win_cnt   = win_q;
  assign lose_cnt  = lose_q;
  assign err       = err_q;

endmodule
